// File: rtl/op_stream_deframer.sv
// Serial deframer for the `op` bit stream: hunts a sync word, deserialises fixed-length frames
// and flywheels over isolated bad syncs. Optional macro DEFRAMER_PARITY_EN adds a per-word even-parity bit.
module op_stream_deframer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int               FRAME_WORDS = 4,
    parameter int               LOSS_LIMIT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_start,
    output logic             locked,
`ifdef DEFRAMER_PARITY_EN
    output logic             parity_err,
`endif
    output logic [7:0]       sync_err_cnt
);

`ifdef DEFRAMER_PARITY_EN
    localparam int WORD_BITS = WIDTH + 1;
`else
    localparam int WORD_BITS = WIDTH;
`endif
    // The live bit completes a word, so only WORD_BITS-1 earlier bits need holding.
    localparam int SHW = WORD_BITS - 1;
    localparam int BW  = $clog2(WORD_BITS + 1);
    localparam int FW  = $clog2(WIDTH + 1);
    localparam int WW  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int MW  = $clog2(LOSS_LIMIT + 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   shift_q, shift_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WW-1:0]    word_q, word_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [7:0]       err_d;
    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] cand;
    logic             dv_d, fs_d;
`ifdef DEFRAMER_PARITY_EN
    logic             perr_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        fill_d  = fill_q;
        bit_d   = bit_q;
        word_d  = word_q;
        miss_d  = miss_q;
        err_d   = sync_err_cnt;
        dout_d  = data_out;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
`ifdef DEFRAMER_PARITY_EN
        perr_d  = 1'b0;
`endif
        cand    = {shift_q[WIDTH-2:0], op_in};
        if (bit_en) begin
            shift_d = cand[SHW-1:0];
            case (state_q)
                HUNT: begin
                    if (fill_q != FW'(WIDTH)) fill_d = fill_q + 1'b1;
                    if (fill_d == FW'(WIDTH) && cand == SYNC_WORD) begin
                        state_d = PAYLOAD;
                        bit_d   = '0;
                        word_d  = '0;
                        miss_d  = '0;
                    end
                end
                PAYLOAD: begin
                    if (bit_q == BW'(WORD_BITS - 1)) begin
                        bit_d = '0;
                        dv_d  = 1'b1;
                        fs_d  = (word_q == '0);
`ifdef DEFRAMER_PARITY_EN
                        dout_d = shift_q;
                        perr_d = ^{shift_q, op_in};
`else
                        dout_d = cand;
`endif
                        if (word_q == WW'(FRAME_WORDS - 1)) begin
                            word_d  = '0;
                            state_d = CHECK;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (bit_q == BW'(WIDTH - 1)) begin
                        bit_d = '0;
                        if (cand == SYNC_WORD) begin
                            miss_d  = '0;
                            state_d = PAYLOAD;
                        end else begin
                            if (sync_err_cnt != 8'hFF) err_d = sync_err_cnt + 8'd1;
                            miss_d = miss_q + 1'b1;
                            // Too many consecutive misses: abandon the flywheel and re-hunt from scratch.
                            if (miss_d == MW'(LOSS_LIMIT)) begin
                                state_d = HUNT;
                                fill_d  = '0;
                            end else begin
                                state_d = PAYLOAD;
                            end
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            fill_q       <= '0;
            bit_q        <= '0;
            word_q       <= '0;
            miss_q       <= '0;
            sync_err_cnt <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
`ifdef DEFRAMER_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            fill_q       <= fill_d;
            bit_q        <= bit_d;
            word_q       <= word_d;
            miss_q       <= miss_d;
            sync_err_cnt <= err_d;
            data_out     <= dout_d;
            data_valid   <= dv_d;
            frame_start  <= fs_d;
            locked       <= (state_d != HUNT);
`ifdef DEFRAMER_PARITY_EN
            parity_err   <= perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_op_stream_deframer.sv
// Directed bench for op_stream_deframer: words expected on the wire are queued as they are
// driven and compared when data_valid strobes; lock and error-count points are checked inline.
module tb_op_stream_deframer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       op_in = 1'b0;
    logic       bit_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       locked;
    logic [7:0] sync_err_cnt;
`ifdef DEFRAMER_PARITY_EN
    logic       parity_err;
    localparam int WORD_BITS = 9;
`else
    localparam int WORD_BITS = 8;
`endif

    op_stream_deframer dut (
        .clk          (clk),
        .reset        (reset),
        .op_in        (op_in),
        .bit_en       (bit_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_start  (frame_start),
        .locked       (locked),
`ifdef DEFRAMER_PARITY_EN
        .parity_err   (parity_err),
`endif
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         n_checks = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    bit         gated = 1'b0;
    int         last_cyc = -1;
    logic       prev_dv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit per call; in gated mode an idle cycle with bit_en=0 follows.
    task automatic send_bit(input logic b);
        @(negedge clk);
        op_in  = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        if (gated) begin
            @(negedge clk);
            op_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_word(input logic [7:0] b, input logic fs);
        exp_q.push_back({fs, b});
        send_byte(b);
`ifdef DEFRAMER_PARITY_EN
        send_bit(^b);
`endif
    endtask

    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
        send_word(w0, 1'b1);
        send_word(w1, 1'b0);
        send_word(w2, 1'b0);
        send_word(w3, 1'b0);
    endtask

    task automatic send_sync_watch(input string tag, input logic [7:0] s,
                                   input logic lock_before, input logic lock_after);
        for (int i = 7; i >= 1; i--) send_bit(s[i]);
        check({tag, "_locked_before_last"}, 32'(locked), 32'(lock_before));
        send_bit(s[0]);
        check({tag, "_locked_after_last"}, 32'(locked), 32'(lock_after));
    endtask

    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (data_valid || frame_start) begin
            check("valid_with_frame_start", 32'(data_valid), 32'd1);
            check("valid_width", 32'(prev_dv), 32'd0);
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL unexpected_valid: observed data %0h expected no strobe", data_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e[7:0]));
                check("frame_start", 32'(frame_start), 32'(e[8]));
`ifdef DEFRAMER_PARITY_EN
                check("parity_err", 32'(parity_err), 32'd0);
`endif
                if (!e[8] && last_cyc >= 0)
                    check("strobe_gap", 32'(cyc - last_cyc), 32'(WORD_BITS * (gated ? 2 : 1)));
            end
            last_cyc = cyc;
        end
        prev_dv = data_valid;
    end

    initial begin
        logic [6:0] pre;
        pre = 7'b1010010;

        // Reset held with random activity on the inputs
        repeat (5) begin
            @(negedge clk);
            op_in  = 1'($urandom_range(0, 1));
            bit_en = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sync_err_cnt", 32'(sync_err_cnt), 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        bit_en = 1'b0;

        // Seven bits never fill the window
        for (int i = 6; i >= 0; i--) send_bit(pre[i]);
        check("short_fill_locked", 32'(locked), 32'd0);

        // Junk, lock, first frame
        repeat (5) send_bit(1'b0);
        send_sync_watch("lock", 8'hA5, 1'b0, 1'b1);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        send_sync_watch("sync1", 8'hA5, 1'b1, 1'b1);
        check("err_after_clean", 32'(sync_err_cnt), 32'd0);

        // Flywheel over a single bad sync
        send_frame(8'h01, 8'h02, 8'h03, 8'h04);
        send_sync_watch("bad_a4", 8'hA4, 1'b1, 1'b1);
        check("err_after_a4", 32'(sync_err_cnt), 32'd1);
        send_frame(8'h55, 8'h66, 8'h77, 8'h88);
        send_sync_watch("sync_after_fly", 8'hA5, 1'b1, 1'b1);
        check("err_after_fly", 32'(sync_err_cnt), 32'd1);

        // Miss counter was cleared: one more bad sync keeps lock, the next drops it
        send_frame(8'h99, 8'hAA, 8'hBB, 8'hCC);
        send_sync_watch("bad_00", 8'h00, 1'b1, 1'b1);
        check("err_after_00", 32'(sync_err_cnt), 32'd2);
        send_frame(8'hA5, 8'h12, 8'h34, 8'h56);
        send_sync_watch("bad_ff", 8'hFF, 1'b1, 1'b0);
        check("err_after_ff", 32'(sync_err_cnt), 32'd3);

        // Hunting again: no strobes until a fresh sync
        send_byte(8'h11);
        send_byte(8'h22);
        check("hunt_locked", 32'(locked), 32'd0);
        send_sync_watch("relock", 8'hA5, 1'b0, 1'b1);
        send_frame(8'h5A, 8'hC3, 8'h3C, 8'hE7);
        send_sync_watch("sync_relock", 8'hA5, 1'b1, 1'b1);
        check("err_held", 32'(sync_err_cnt), 32'd3);

        // Asynchronous reset in the middle of word 2
        send_word(8'h10, 1'b1);
        send_word(8'h20, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_data_out", 32'(data_out), 32'd0);
        check("async_locked", 32'(locked), 32'd0);
        check("async_sync_err_cnt", 32'(sync_err_cnt), 32'd0);
        check("async_data_valid", 32'(data_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send_sync_watch("post_async_lock", 8'hA5, 1'b0, 1'b1);
        send_frame(8'h0F, 8'hF0, 8'h55, 8'hAA);
        send_sync_watch("post_async_sync", 8'hA5, 1'b1, 1'b1);

        // Lock scenario again with bit_en toggling
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        gated = 1'b1;
        repeat (5) send_bit(1'b0);
        send_sync_watch("gated_lock", 8'hA5, 1'b0, 1'b1);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        send_sync_watch("gated_sync", 8'hA5, 1'b1, 1'b1);
        check("gated_err", 32'(sync_err_cnt), 32'd0);
        gated = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("all_words_delivered", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/op_stream_deframer.md
Name: op_stream_deframer

Overview:
- Downstream consumer of the 1-bit `op` serial stream produced by `main`.
- Hunts for a fixed sync word in the bit stream, then deserialises a fixed-length frame of payload words MSB-first and presents each word with a one-cycle valid strobe.
- Tolerates isolated sync errors using a flywheel, and reports lock status and an error count to downstream logic.

Parameters:
- WIDTH, 8, bits per sync word and per payload word
- SYNC_WORD, 8'hA5, frame sync pattern, WIDTH bits, MSB first on the wire
- FRAME_WORDS, 4, payload words between consecutive sync words (>=1)
- LOSS_LIMIT, 2, consecutive bad sync words that drop lock (>=1)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- op_in  input  1  serial bit from `main` `op`
- bit_en  input  1  bit strobe; op_in is sampled only on edges where bit_en=1
- data_out  output  WIDTH  last completed payload word; holds its value between strobes
- data_valid  output  1  one-cycle pulse, high when data_out is newly updated
- frame_start  output  1  pulse coincident with data_valid for payload word 0 of each frame
- locked  output  1  1 while in PAYLOAD or CHECK
- sync_err_cnt  output  8  count of bad sync words, saturates at 255, cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, data_valid=0, frame_start=0, locked=0, sync_err_cnt=0.
  - Shift register=0, fill count=0, bit/word/miss counters=0, state=HUNT.
  - Reset asserted mid-word or mid-frame discards all partial data; after release the block re-hunts.
- Sampling and shift register:
  - A bit is sampled on an edge where bit_en=1; no state changes when bit_en=0 except pulse deassertion.
  - The shift register takes op_in at the LSB, so the first-received bit ends as the MSB.
- HUNT:
  - Fill count saturates at WIDTH. No match is allowed until WIDTH bits have been sampled since reset.
  - On a sampled edge where fill=WIDTH and the updated shift value equals SYNC_WORD:
    - go to PAYLOAD
    - set locked=1 on that same edge
    - clear bit_cnt, word_cnt and miss_cnt
- PAYLOAD:
  - Each sampled bit increments bit_cnt.
  - On the edge that samples bit WIDTH of a word, data_out takes the assembled word and data_valid=1. Latency: outputs are registered and visible the cycle after the last bit's edge, for exactly 1 cycle.
  - frame_start=1 on the same edge when word_cnt=0.
  - After word FRAME_WORDS-1 completes, go to CHECK.
  - Payload bits equal to SYNC_WORD are never treated as sync.
- CHECK:
  - Collect WIDTH bits, with no data_valid pulse.
  - Match: miss_cnt=0, go to PAYLOAD.
  - Mismatch: sync_err_cnt+1 (saturating) and miss_cnt+1.
    - If miss_cnt reaches LOSS_LIMIT: locked=0 on that edge, go to HUNT, fill count reset to 0.
    - Otherwise go to PAYLOAD (flywheel).
- data_valid and frame_start return to 0 on the next clock edge regardless of bit_en.
- Counters are sized with $clog2 of their parameter; there is no wrap inside a frame.

Optional Feature:
- Macro DEFRAMER_PARITY_EN.
- Defined:
  - Each payload word is followed by one even-parity bit, so a word occupies WIDTH+1 sampled bits.
  - data_out and data_valid update on the edge that samples the parity bit.
  - An extra output port parity_err (1 bit) pulses together with data_valid when the XOR of the word and the parity bit is 1.
  - The word is still delivered when parity_err pulses.
  - Sync words carry no parity bit.
- Undefined: no parity bit in the frame, no parity_err port, and the frame format is exactly as described above.

Test Plan:
- Reset: hold reset=0 for 5 clocks while driving random op_in -> all outputs 0; release reset, drive 7 bits of 1010010 then stop -> locked stays 0, because fill never reaches 8.
- Lock and deframe: bit_en=1, send 5 junk bits, then A5, 11, 22, 33, 44, A5 ->
  - locked rises on the 8th sync bit
  - data_valid pulses 8 cycles apart carrying 11, 22, 33, 44
  - frame_start only with 11
  - sync_err_cnt=0
- Flywheel: after lock send sync A4 followed by payload 55, 66, 77, 88, then A5 -> sync_err_cnt=1, locked stays 1, all four words delivered, miss counter cleared.
- Loss of lock: send two consecutive bad syncs (00, FF) ->
  - sync_err_cnt +2
  - locked falls on the last bit of the second bad sync
  - no data_valid until a new A5 is found
  - a payload word equal to A5 does not cause resync while locked
- Gating: repeat the lock scenario with bit_en toggling 1,0,1,0 -> identical words, pulses 16 cycles apart, each pulse exactly 1 cycle wide.
- Async reset mid-frame: pull reset low between edges during word 2 -> outputs clear immediately without waiting for a clock; after release the block requires a full A5 to relock.
